uart_boot_loader: RTL and testbench

- Sits between the UART RX FIFO and the instruction memory write port, directly upstream of the pipeline fetch stage.
- After reset it holds the core in reset and receives a framed program image over UART. It writes the image word by word into instruction memory, verifies a checksum, then releases the core.
- Once released, it stops reading the RX FIFO, so the running program owns the UART.

---
 rtl/uart_boot_loader.sv | 175 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image from the RX FIFO, writes it
// into instruction memory, verifies its checksum and then releases the core.
module uart_boot_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              skip_boot,
    input  logic [7:0]        rx_fifo_data_out,
    input  logic              rx_fifo_empty,
    output logic              rx_fifo_rd,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              boot_done,
    output logic              boot_error
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        len_lo, len_lo_nxt;
    logic [15:0]       len, len_nxt;
    logic [15:0]       word_idx, word_idx_nxt;
    logic [1:0]        byte_idx, byte_idx_nxt;
    logic [23:0]       word_buf, word_buf_nxt;
    logic [7:0]        checksum, checksum_nxt;
    logic [TO_W-1:0]   idle_cnt, idle_nxt, idle_inc;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       wdata_nxt;
    logic              pop, timed;
    logic [15:0]       rx_len;

    // Pop whenever a byte is present, except once booted or while skip_boot wins in IDLE
    assign pop = reset && !rx_fifo_empty && (state != DONE) && !((state == IDLE) && skip_boot);
    assign timed = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
    assign rx_len = {rx_fifo_data_out, len_lo};
    assign idle_inc = idle_cnt + TO_W'(1);
    assign rx_fifo_rd = pop;

    // Next-state and datapath updates
    always_comb begin
        state_nxt    = state;
        len_lo_nxt   = len_lo;
        len_nxt      = len;
        word_idx_nxt = word_idx;
        byte_idx_nxt = byte_idx;
        word_buf_nxt = word_buf;
        checksum_nxt = checksum;
        wr_en_nxt    = 1'b0;
        addr_nxt     = imem_addr;
        wdata_nxt    = imem_wdata;
        idle_nxt     = '0;

        case (state)
            IDLE: begin
                if (skip_boot) begin
                    state_nxt = DONE;
                end else if (pop && (rx_fifo_data_out == SYNC_BYTE)) begin
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                if (pop) begin
                    len_lo_nxt = rx_fifo_data_out;
                    state_nxt  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (pop) begin
                    len_nxt      = rx_len;
                    word_idx_nxt = '0;
                    byte_idx_nxt = '0;
                    checksum_nxt = '0;
                    if (32'(rx_len) > MAX_WORDS) begin
                        state_nxt = ERROR;
                    end else if (rx_len == 16'd0) begin
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (pop) begin
                    checksum_nxt = checksum + rx_fifo_data_out;
                    byte_idx_nxt = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    word_buf_nxt[7:0]   = rx_fifo_data_out;
                        2'd1:    word_buf_nxt[15:8]  = rx_fifo_data_out;
                        2'd2:    word_buf_nxt[23:16] = rx_fifo_data_out;
                        default: begin
                            wr_en_nxt    = 1'b1;
                            addr_nxt     = ADDR_W'({word_idx, 2'b00});
                            wdata_nxt    = {rx_fifo_data_out, word_buf};
                            word_idx_nxt = word_idx + 16'd1;
                            if (word_idx == (len - 16'd1)) begin
                                state_nxt = CHECK;
                            end
                        end
                    endcase
                end
            end
            CHECK: begin
                if (pop) begin
                    state_nxt = (rx_fifo_data_out == checksum) ? DONE : ERROR;
                end
            end
            ERROR: begin
                if (pop && (rx_fifo_data_out == SYNC_BYTE)) begin
                    state_nxt = LEN_LO;
                end
            end
            default: ;
        endcase

        // A popped byte beats the timeout in the same cycle
        if (timed && !pop && (idle_inc == TO_W'(TIMEOUT_CYCLES))) begin
            state_nxt = ERROR;
        end
        if (timed && !pop && (state_nxt == state)) begin
            idle_nxt = idle_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            len_lo       <= '0;
            len          <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            checksum     <= '0;
            idle_cnt     <= '0;
            imem_wr_en   <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_reset_n <= 1'b0;
            boot_done    <= 1'b0;
            boot_error   <= 1'b0;
        end else begin
            state        <= state_nxt;
            len_lo       <= len_lo_nxt;
            len          <= len_nxt;
            word_idx     <= word_idx_nxt;
            byte_idx     <= byte_idx_nxt;
            word_buf     <= word_buf_nxt;
            checksum     <= checksum_nxt;
            idle_cnt     <= idle_nxt;
            imem_wr_en   <= wr_en_nxt;
            imem_addr    <= addr_nxt;
            imem_wdata   <= wdata_nxt;
            core_reset_n <= (state_nxt == DONE);
            boot_done    <= (state_nxt == DONE);
            boot_error   <= (state_nxt == ERROR);
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: byte-stream reference model compared every cycle,
// directed frames from the test plan plus randomized frames with FIFO gaps.
module tb_uart_boot_loader;

    localparam int unsigned T    = 40;
    localparam int unsigned MAXW = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        skip_boot;
    logic [7:0]  rx_fifo_data_out;
    logic        rx_fifo_empty;
    logic        rx_fifo_rd;
    logic        imem_wr_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset_n;
    logic        boot_done;
    logic        boot_error;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .SYNC_BYTE(8'hA5), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(T), .ADDR_W(32)
    ) dut (
        .clk(clk), .reset(reset), .skip_boot(skip_boot),
        .rx_fifo_data_out(rx_fifo_data_out), .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_rd(rx_fifo_rd), .imem_wr_en(imem_wr_en), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_reset_n(core_reset_n),
        .boot_done(boot_done), .boot_error(boot_error)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q[$];
    bit          gaps_en = 1'b0;
    bit          pop_q = 1'b0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    // Reference model: position within the frame byte stream
    bit          m_done, m_err, m_in;
    int          m_pos, m_n, m_idle;
    logic [7:0]  m_sum, m_lo;
    logic [31:0] m_buf;
    logic        e_wr;
    logic [31:0] e_addr, e_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO: pop on the edge the DUT consumed, then present the next head
    always begin
        @(posedge clk);
        if (pop_q && q.size() > 0) q.delete(0);
        #1;
        rx_fifo_empty    = (q.size() == 0) || (gaps_en && ($urandom_range(0, 3) == 0));
        rx_fifo_data_out = (q.size() > 0) ? q[0] : 8'h00;
    end

    // Per-cycle comparison and model step
    always @(negedge clk) begin
        logic       e_rd;
        logic [7:0] b;
        int         k;
        if (!reset) begin
            m_done = 0; m_err = 0; m_in = 0; m_pos = 0; m_n = 0; m_idle = 0;
            m_sum = '0; m_lo = '0; m_buf = '0;
            e_wr = 0; e_addr = '0; e_wdata = '0;
            chk("rst_rd", 32'(rx_fifo_rd), 0);
            chk("rst_wr_en", 32'(imem_wr_en), 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_wdata", imem_wdata, 0);
            chk("rst_core_reset_n", 32'(core_reset_n), 0);
            chk("rst_boot_done", 32'(boot_done), 0);
            chk("rst_boot_error", 32'(boot_error), 0);
            pop_q = 0;
        end else begin
            chk("wr_en", 32'(imem_wr_en), 32'(e_wr));
            chk("addr", imem_addr, e_addr);
            chk("wdata", imem_wdata, e_wdata);
            chk("core_reset_n", 32'(core_reset_n), 32'(m_done));
            chk("boot_done", 32'(boot_done), 32'(m_done));
            chk("boot_error", 32'(boot_error), 32'(m_err));
            if (imem_wr_en) begin
                wa.push_back(imem_addr);
                wd.push_back(imem_wdata);
            end
            e_rd = !rx_fifo_empty && !m_done && !(!m_in && !m_err && skip_boot);
            chk("rx_fifo_rd", 32'(rx_fifo_rd), 32'(e_rd));
            pop_q = rx_fifo_rd;
            b = rx_fifo_data_out;
            e_wr = 0;
            if (m_done) begin
            end else if (!m_in) begin
                if (!m_err && skip_boot) m_done = 1;
                else if (e_rd && b == 8'hA5) begin
                    m_in = 1; m_pos = 1; m_err = 0; m_idle = 0;
                end
            end else if (e_rd) begin
                m_idle = 0;
                if (m_pos == 1) begin
                    m_lo = b; m_pos = 2;
                end else if (m_pos == 2) begin
                    m_n = int'({b, m_lo}); m_sum = 0;
                    if (m_n > MAXW) begin m_err = 1; m_in = 0; end
                    else m_pos = 3;
                end else if (m_pos < 3 + 4 * m_n) begin
                    k = m_pos - 3;
                    m_buf[8*(k%4) +: 8] = b;
                    m_sum = m_sum + b;
                    if (k % 4 == 3) begin
                        e_wr = 1; e_addr = 32'((k / 4) * 4); e_wdata = m_buf;
                    end
                    m_pos++;
                end else begin
                    if (b == m_sum) m_done = 1; else m_err = 1;
                    m_in = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == T) begin m_err = 1; m_in = 0; m_idle = 0; end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 0;
        q.delete();
        step(2);
        reset = 1;
        wa.delete();
        wd.delete();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin step(1); n++; end
        if (q.size() > 0) chk("drain_budget", 32'(q.size()), 0);
        step(3);
    endtask

    task automatic add_frame(input logic [31:0] w[$], input bit bad);
        logic [7:0] s = 8'h00;
        logic [15:0] n16 = 16'(w.size());
        q.push_back(8'hA5);
        q.push_back(n16[7:0]);
        q.push_back(n16[15:8]);
        foreach (w[i]) begin
            for (int j = 0; j < 4; j++) begin
                q.push_back(w[i][8*j +: 8]);
                s = s + w[i][8*j +: 8];
            end
        end
        q.push_back(bad ? s + 8'd1 : s);
    endtask

    task automatic check_prog_writes(input string tag, input int base);
        chk({tag, "_wcount"}, 32'(wa.size()), 32'(base + 2));
        if (wa.size() >= base + 2) begin
            chk({tag, "_a0"}, wa[base], 32'h0);
            chk({tag, "_d0"}, wd[base], 32'h00000013);
            chk({tag, "_a1"}, wa[base+1], 32'h4);
            chk({tag, "_d1"}, wd[base+1], 32'h00100093);
        end
    endtask

    logic [31:0] prog[$];
    logic [31:0] none[$];
    logic [31:0] rw[$];

    initial begin
        reset = 0; skip_boot = 0; rx_fifo_empty = 1; rx_fifo_data_out = 8'h00;
        prog.push_back(32'h00000013);
        prog.push_back(32'h00100093);
        step(3);
        reset = 1;
        gaps_en = 1;

        // Valid two-word load, then a byte left in the FIFO must not be popped
        do_reset();
        chk("post_rst_core_reset_n", 32'(core_reset_n), 0);
        chk("post_rst_boot_done", 32'(boot_done), 0);
        add_frame(prog, 0);
        drain(200);
        check_prog_writes("load", 0);
        chk("load_done", 32'(boot_done), 1);
        chk("load_core_reset_n", 32'(core_reset_n), 1);
        q.push_back(8'h55);
        step(6);
        chk("done_no_pop", 32'(q.size()), 1);

        // Bad checksum then retry
        do_reset();
        add_frame(prog, 1);
        drain(200);
        chk("bad_err", 32'(boot_error), 1);
        chk("bad_core_reset_n", 32'(core_reset_n), 0);
        add_frame(prog, 0);
        drain(200);
        chk("retry_err", 32'(boot_error), 0);
        chk("retry_done", 32'(boot_done), 1);
        check_prog_writes("retry", 2);

        // Leading garbage
        do_reset();
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h5A);
        add_frame(prog, 0);
        drain(200);
        check_prog_writes("garbage", 0);
        chk("garbage_done", 32'(boot_done), 1);

        // Zero-length frame
        do_reset();
        add_frame(none, 0);
        drain(100);
        chk("zero_done", 32'(boot_done), 1);
        chk("zero_writes", 32'(wa.size()), 0);

        // Length MAX_WORDS+1
        do_reset();
        q.push_back(8'hA5); q.push_back(8'h01); q.push_back(8'h04);
        drain(100);
        chk("len_err", 32'(boot_error), 1);
        chk("len_not_done", 32'(boot_done), 0);

        // Timeout after byte 2 of a word
        do_reset();
        gaps_en = 0;
        q.push_back(8'hA5); q.push_back(8'h01); q.push_back(8'h00);
        q.push_back(8'h13); q.push_back(8'h00);
        drain(100);
        chk("pre_timeout_err", 32'(boot_error), 0);
        step(T + 5);
        chk("timeout_err", 32'(boot_error), 1);
        gaps_en = 1;

        // Reset pulsed mid-DATA, then a full frame
        do_reset();
        add_frame(prog, 0);
        begin
            int n = 0;
            while (q.size() > 6 && n < 200) begin step(1); n++; end
        end
        do_reset();
        chk("midrst_wr_en", 32'(imem_wr_en), 0);
        chk("midrst_boot_error", 32'(boot_error), 0);
        add_frame(prog, 0);
        drain(200);
        check_prog_writes("midrst", 0);
        chk("midrst_done", 32'(boot_done), 1);

        // skip_boot with a SYNC byte waiting
        do_reset();
        gaps_en = 0;
        skip_boot = 1;
        q.push_back(8'hA5);
        step(3);
        chk("skip_done", 32'(boot_done), 1);
        chk("skip_core_reset_n", 32'(core_reset_n), 1);
        chk("skip_no_pop", 32'(q.size()), 1);
        chk("skip_no_write", 32'(wa.size()), 0);
        skip_boot = 0;
        gaps_en = 1;

        // Randomized frames
        for (int it = 0; it < 8; it++) begin
            int nw;
            bit bad;
            do_reset();
            rw.delete();
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                logic [7:0] gb = 8'($urandom);
                q.push_back(gb == 8'hA5 ? 8'h00 : gb);
            end
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++) rw.push_back($urandom);
            bad = ($urandom_range(0, 3) == 0);
            add_frame(rw, bad);
            if (bad) add_frame(rw, 0);
            drain(600);
            chk("rand_done", 32'(boot_done), 1);
            chk("rand_writes", 32'(wa.size()), 32'(bad ? 2 * nw : nw));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
